// File: rtl/debug_bus_master.sv
// Debug bus initiator driven by SPI command frames: assembles read/write frames,
// issues a single-cycle strobe on the 32-bit debug bus and streams the response bytes back.
module debug_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  ACK_BYTE       = 8'hAC,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] debug_addr,
  output logic [31:0] debug_write_data,
  output logic        debug_read,
  output logic        debug_write,
  input  logic [31:0] debug_read_data,
  output logic        busy,
  output logic        err_cmd,
  output logic        err_timeout,
  output logic        rx_overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_ISSUE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_READ  = 8'h01;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  // Abort is taken on the edge where the idle count would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic        op_write_r;
  logic [1:0]  byte_cnt_r;
  logic [15:0] tmo_cnt_r;
  logic [31:0] resp_r;
  logic [2:0]  resp_cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        read_r;
  logic        write_r;
  logic [7:0]  tx_data_r;
  logic        tx_valid_r;
  logic        busy_r;
  logic        err_cmd_r;
  logic        err_timeout_r;
  logic        rx_overrun_r;

  assign tx_data          = tx_data_r;
  assign tx_valid         = tx_valid_r;
  assign debug_addr       = addr_r;
  assign debug_write_data = wdata_r;
  assign debug_read       = read_r;
  assign debug_write      = write_r;
  assign busy             = busy_r;
  assign err_cmd          = err_cmd_r;
  assign err_timeout      = err_timeout_r;
  assign rx_overrun       = rx_overrun_r;

  // Frame sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      op_write_r    <= 1'b0;
      byte_cnt_r    <= 2'd0;
      tmo_cnt_r     <= 16'd0;
      resp_r        <= 32'd0;
      resp_cnt_r    <= 3'd0;
      addr_r        <= 32'd0;
      wdata_r       <= 32'd0;
      read_r        <= 1'b0;
      write_r       <= 1'b0;
      tx_data_r     <= 8'd0;
      tx_valid_r    <= 1'b0;
      busy_r        <= 1'b0;
      err_cmd_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      rx_overrun_r  <= 1'b0;
    end else begin
      read_r        <= 1'b0;
      write_r       <= 1'b0;
      err_cmd_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      rx_overrun_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          tmo_cnt_r <= 16'd0;
          if (rx_valid) begin
            busy_r <= 1'b1;
            if ((rx_data == CMD_READ) || (rx_data == CMD_WRITE)) begin
              op_write_r <= (rx_data == CMD_WRITE);
              byte_cnt_r <= 2'd0;
              state_r    <= S_ADDR;
            end else begin
              err_cmd_r  <= 1'b1;
              tx_data_r  <= ERR_BYTE;
              resp_r     <= 32'd0;
              resp_cnt_r <= 3'd1;
              tx_valid_r <= 1'b1;
              state_r    <= S_RESP;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        S_ADDR, S_WDATA: begin
          if (rx_valid) begin
            tmo_cnt_r  <= 16'd0;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (state_r == S_ADDR) begin
              addr_r <= {addr_r[23:0], rx_data};
            end else begin
              wdata_r <= {wdata_r[23:0], rx_data};
            end
            // byte_cnt wraps to 0 on the 4th byte, ready for the data phase.
            if (byte_cnt_r == 2'd3) begin
              if ((state_r == S_ADDR) && op_write_r) begin
                state_r <= S_WDATA;
              end else begin
                state_r <= S_ISSUE;
                read_r  <= ~op_write_r;
                write_r <= op_write_r;
              end
            end else begin
              state_r <= state_r;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_cnt_r     <= 16'd0;
            err_timeout_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= S_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
        end

        S_ISSUE: begin
          tmo_cnt_r    <= 16'd0;
          rx_overrun_r <= rx_valid;
          tx_valid_r   <= 1'b1;
          state_r      <= S_RESP;
          if (op_write_r) begin
            tx_data_r  <= ACK_BYTE;
            resp_r     <= 32'd0;
            resp_cnt_r <= 3'd1;
          end else begin
            tx_data_r  <= debug_read_data[31:24];
            resp_r     <= {debug_read_data[23:0], 8'd0};
            resp_cnt_r <= 3'd4;
          end
        end

        S_RESP: begin
          tmo_cnt_r    <= 16'd0;
          rx_overrun_r <= rx_valid;
          if (tx_ready) begin
            tx_data_r  <= resp_r[31:24];
            resp_r     <= {resp_r[23:0], 8'd0};
            resp_cnt_r <= resp_cnt_r - 3'd1;
            if (resp_cnt_r == 3'd1) begin
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= S_IDLE;
            end else begin
              state_r <= S_RESP;
            end
          end else begin
            state_r <= S_RESP;
          end
        end

        default: begin
          tmo_cnt_r  <= 16'd0;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed bench for debug_bus_master: read, write, illegal command, timeout,
// backpressure with overrun, and reset in the middle of a write frame.
module tb_debug_bus_master;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] debug_addr;
  logic [31:0] debug_write_data;
  logic        debug_read;
  logic        debug_write;
  logic [31:0] debug_read_data;
  logic        busy;
  logic        err_cmd;
  logic        err_timeout;
  logic        rx_overrun;

  int checks;
  int errors;
  int rd_pulses;
  int wr_pulses;
  logic both_seen;

  debug_bus_master #(
    .TIMEOUT_CYCLES(16),
    .ACK_BYTE(8'hAC),
    .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .debug_addr(debug_addr),
    .debug_write_data(debug_write_data),
    .debug_read(debug_read),
    .debug_write(debug_write),
    .debug_read_data(debug_read_data),
    .busy(busy),
    .err_cmd(err_cmd),
    .err_timeout(err_timeout),
    .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (debug_read) rd_pulses <= rd_pulses + 1;
    if (debug_write) wr_pulses <= wr_pulses + 1;
    if (debug_read && debug_write) both_seen <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(f[8*(n-i)-1 -: 8]);
  endtask

  // Drain n response bytes, holding tx_ready low for 'hold' cycles before each.
  task automatic expect_resp(input string tag, input logic [31:0] exp, input int n, input int hold);
    logic [7:0] eb;
    for (int i = 0; i < n; i++) begin
      eb = exp[31-8*i -: 8];
      for (int h = 0; h < hold; h++) begin
        check_eq({tag, "_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, eb});
        step();
      end
      check_eq({tag, "_byte"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, eb});
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    check_eq({tag, "_done_txv"}, {31'd0, tx_valid}, 32'd0);
    check_eq({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; rd_pulses = 0; wr_pulses = 0; both_seen = 1'b0;
    rst = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b0;
    debug_read_data = 32'hDEB0_6001;
    #12;
    check_eq("rst_addr", debug_addr, 32'd0);
    check_eq("rst_wdata", debug_write_data, 32'd0);
    check_eq("rst_flags", {24'd0, tx_valid, busy, debug_read, debug_write, err_cmd, err_timeout, rx_overrun, 1'b0}, 32'd0);
    check_eq("rst_txdata", {24'd0, tx_data}, 32'd0);
    rst = 1'b1;
    step();

    // Plain read
    send_frame(72'h01_2000_0014, 5);
    check_eq("rd_strobe", {30'd0, debug_read, debug_write}, 32'd2);
    check_eq("rd_addr", debug_addr, 32'h2000_0014);
    check_eq("rd_txv_n1", {31'd0, tx_valid}, 32'd0);
    step();
    check_eq("rd_strobe_off", {30'd0, debug_read, debug_write}, 32'd0);
    expect_resp("rd", 32'hDEB0_6001, 4, 0);
    check_eq("rd_addr_hold", debug_addr, 32'h2000_0014);

    // Read with backpressure and an overrun byte during RESP
    send_frame(72'h01_2000_0014, 5);
    step();
    send_byte(8'h01);
    check_eq("ovr_pulse", {31'd0, rx_overrun}, 32'd1);
    check_eq("ovr_tx", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hDE});
    step();
    check_eq("ovr_clear", {31'd0, rx_overrun}, 32'd0);
    expect_resp("bp", 32'hDEB0_6001, 4, 5);
    check_eq("bp_rd_cnt", rd_pulses, 32'd2);

    // Write; a command byte in the same cycle as the final accept is dropped
    send_frame(72'h02_2000_0018_1234_5678, 9);
    check_eq("wr_strobe", {30'd0, debug_read, debug_write}, 32'd1);
    check_eq("wr_addr", debug_addr, 32'h2000_0018);
    check_eq("wr_data", debug_write_data, 32'h1234_5678);
    step();
    check_eq("wr_ack", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAC});
    tx_ready = 1'b1; rx_data = 8'h01; rx_valid = 1'b1;
    step();
    tx_ready = 1'b0; rx_valid = 1'b0;
    check_eq("wr_last_ovr", {29'd0, rx_overrun, tx_valid, busy}, 32'd4);
    step();
    check_eq("wr_drop_idle", {31'd0, busy}, 32'd0);
    check_eq("wr_cnts", {rd_pulses[15:0], wr_pulses[15:0]}, {16'd2, 16'd1});

    // Illegal command then a normal read
    send_byte(8'h7F);
    check_eq("ill_pulse", {29'd0, err_cmd, tx_valid, busy}, 32'd7);
    check_eq("ill_byte", {24'd0, tx_data}, 32'h0000_00EE);
    step();
    check_eq("ill_once", {31'd0, err_cmd}, 32'd0);
    expect_resp("ill", 32'hEE00_0000, 1, 0);
    check_eq("ill_no_strobe", {rd_pulses[15:0], wr_pulses[15:0]}, {16'd2, 16'd1});
    debug_read_data = 32'hA5A5_5A5A;
    send_frame(72'h01_0000_0004, 5);
    check_eq("ill_rd_addr", debug_addr, 32'h0000_0004);
    step();
    expect_resp("ill_rd", 32'hA5A5_5A5A, 4, 1);

    // Timeout after 16 idle cycles
    send_frame(72'h01_20, 2);
    for (int i = 0; i < 15; i++) step();
    check_eq("tmo_before", {30'd0, err_timeout, busy}, 32'd1);
    step();
    check_eq("tmo_pulse", {29'd0, err_timeout, busy, tx_valid}, 32'd4);
    step();
    check_eq("tmo_once", {31'd0, err_timeout}, 32'd0);
    check_eq("tmo_no_strobe", rd_pulses, 32'd3);
    debug_read_data = 32'hDEB0_6001;
    send_frame(72'h01_2000_0014, 5);
    check_eq("tmo_rd_addr", debug_addr, 32'h2000_0014);
    step();
    expect_resp("tmo_rd", 32'hDEB0_6001, 4, 0);

    // Reset in the middle of the data phase
    send_frame(72'h02_1122_3344_AABB, 7);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_addr", debug_addr, 32'd0);
    check_eq("mid_rst_wdata", debug_write_data, 32'd0);
    check_eq("mid_rst_flags", {25'd0, tx_valid, busy, debug_read, debug_write, err_cmd, err_timeout, rx_overrun}, 32'd0);
    #2 rst = 1'b1;
    step();
    step();
    check_eq("mid_rst_no_wr", wr_pulses, 32'd1);
    send_frame(72'h02_CAFE_0008_8765_4321, 9);
    check_eq("wr2_strobe", {30'd0, debug_read, debug_write}, 32'd1);
    check_eq("wr2_addr", debug_addr, 32'hCAFE_0008);
    check_eq("wr2_data", debug_write_data, 32'h8765_4321);
    step();
    expect_resp("wr2", 32'hAC00_0000, 1, 2);
    step();
    check_eq("final_cnts", {rd_pulses[15:0], wr_pulses[15:0]}, {16'd4, 16'd2});
    check_eq("strobe_excl", {31'd0, both_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_bus_master.md
# debug_bus_master

Byte-stream initiator for the 32-bit debug register bus. It accepts command frames from the SPI byte receiver and issues single-cycle `debug_read`/`debug_write` strobes toward the debug register file. It returns read data, or a write acknowledge, as bytes to the SPI byte transmitter. This block lets an external host inspect SPI status, error counters and the debug control word without processor involvement.

## Interface
- `TIMEOUT_CYCLES`, 1000: max idle cycles between bytes of one frame before abort; range 2..65535.
- `ACK_BYTE`, 8'hAC: response byte after a completed write.
- `ERR_BYTE`, 8'hEE: response byte after an illegal command byte.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse; `rx_data` valid this cycle.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` valid; held until accepted.
- `tx_ready` in 1: transmitter accepts byte when `tx_valid && tx_ready`.
- `debug_addr` out 32: bus address.
- `debug_write_data` out 32: bus write data.
- `debug_read` out 1: one-cycle read strobe.
- `debug_write` out 1: one-cycle write strobe.
- `debug_read_data` in 32: combinational read data, valid in the `debug_read` cycle.
- `busy` out 1: high in any state other than IDLE.
- `err_cmd` out 1: one-cycle pulse on an illegal command byte.
- `err_timeout` out 1: one-cycle pulse on an inter-byte timeout abort.
- `rx_overrun` out 1: one-cycle pulse when `rx_valid` arrives in ISSUE or RESP; that byte is dropped.

## Operation
- Frame format:
  - Read frame: cmd 8'h01, then addr[31:24], [23:16], [15:8], [7:0].
  - Write frame: cmd 8'h02, then 4 addr bytes MSB first, then 4 data bytes MSB first.
- States: IDLE, ADDR, WDATA, ISSUE, RESP.
- IDLE, on `rx_valid`:
  - 01 or 02: latch the op, clear `byte_cnt`, go to ADDR.
  - Any other value: pulse `err_cmd`, load `ERR_BYTE` as a 1-byte response, go to RESP.
- ADDR: each `rx_valid` shifts the byte into `debug_addr` from the LSB end (`addr <= {addr[23:0], rx_data}`) and increments the 2-bit `byte_cnt`. On the 4th byte, go to ISSUE (read) or WDATA (write, `byte_cnt` cleared).
- WDATA: same shifting into `debug_write_data`. On the 4th byte, go to ISSUE.
- ISSUE (one cycle):
  - Assert `debug_read` or `debug_write`.
  - Read: capture `debug_read_data` into a 32-bit response shift register; response length is 4 bytes.
  - Write: response is `ACK_BYTE`; length is 1.
  - Go to RESP.
- RESP:
  - `tx_data` is the response MSB; `tx_valid` is 1.
  - On each `tx_ready`, shift left 8 bits and decrement the count. After the last byte is accepted, go to IDLE.
- Timeout:
  - In ADDR/WDATA, a 16-bit counter clears on every `rx_valid` and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`: pulse `err_timeout`, go to IDLE, no bus strobe, no response.
  - The counter is held at 0 outside ADDR/WDATA.
- `debug_addr` and `debug_write_data` hold their last values in all states; they are not cleared at frame start and are overwritten by shifting.

## Timing
- Reset: state IDLE. All of these are 0: `debug_addr`, `debug_write_data`, `debug_read`, `debug_write`, `tx_data`, `tx_valid`, `busy`, `err_cmd`, `err_timeout`, `rx_overrun`, counters.
- Reset asserted mid-frame or mid-response: immediate return to IDLE, strobes and `tx_valid` drop asynchronously, and the partial frame is discarded.
- Last frame byte at cycle N: ISSUE at N+1 with the strobe high exactly that cycle; `tx_valid` rises at N+2.
- `debug_addr` is stable from N+1 until the next frame's first addr byte.
- `tx_valid` stays high with `tx_data` stable while `tx_ready` is low. `tx_valid && tx_ready` at cycle M presents the next byte at M+1; there is no bubble.
- A command byte arriving in the same cycle the last response byte is accepted is dropped and `rx_overrun` pulses.
- Timeout with `TIMEOUT_CYCLES`=T: the abort occurs on the T-th consecutive cycle without `rx_valid`. A byte arriving on that same cycle wins, so there is no abort.
- `debug_read` and `debug_write` are never asserted together.

## Test plan
- Read: send 01 20 00 00 14 with `debug_read_data`=DEB0_6001 in ISSUE -> `debug_read` high one cycle with addr 2000_0014; tx bytes DE B0 60 01.
- Write: send 02 20 00 00 18 12 34 56 78 -> `debug_write` one cycle with addr 2000_0018 and data 1234_5678; tx byte AC; no `debug_read`.
- Illegal cmd: send 7F -> `err_cmd` one pulse; tx EE; no strobe; back to IDLE; a following read frame completes normally.
- Timeout with T=16: send 01 20 then silence -> `err_timeout` 16 cycles after byte 20; IDLE; no tx; a new read frame completes.
- Backpressure: read with `tx_ready` low 5 cycles per byte -> each byte held stable, 4 bytes delivered in order; an `rx_valid` during RESP pulses `rx_overrun` and the byte is ignored.
- Reset mid-WDATA after 2 data bytes -> all outputs 0; no `debug_write`; a subsequent full write frame works.
